// File: rtl/proc_pkg.sv
// Shared constants and types for the fetch/decode pipeline.
// Instruction format: opcode in the top four bits of a 14-bit word.
package proc_pkg;

    localparam int PC_W    = 8;
    localparam int INSTR_W = 14;
    localparam int OPC_HI  = 13;
    localparam int OPC_LO  = 10;

    localparam logic [OPC_HI-OPC_LO:0] HALT_OP  = 4'hF;
    localparam logic [INSTR_W-1:0]     NOP_WORD = 14'h0000;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_e;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[OPC_HI:OPC_LO] == HALT_OP;
    endfunction

endpackage

// File: rtl/pc_next_mux.sv
// Selects the instruction-memory address for the current cycle:
// branch redirect, stall re-read of the in-flight address, or the next PC.
module pc_next_mux
    import proc_pkg::*;
(
    input  logic            rst_n,
    input  logic            run,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    input  logic [PC_W-1:0] pc_q,
    input  logic [PC_W-1:0] addr_q,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd
);

    // NOTE: every output gets a default first so no path through the block infers a latch.
    always_comb begin
        imem_addr = '0;
        imem_rd   = 1'b0;
        if (rst_n) begin
            if (!run) begin
                imem_addr = pc_q;
            end else begin
                imem_rd = 1'b1;
                if (branch_taken) begin
                    imem_addr = branch_target;
                end else if (stall) begin
                    // Re-reading the in-flight address keeps imem_data stable for next cycle.
                    imem_addr = addr_q;
                end else begin
                    imem_addr = pc_q;
                end
            end
        end
    end

endmodule

// File: rtl/etapa_if.sv
// Instruction-fetch stage with IF/ID register: PC generation, 1-cycle ROM,
// stall hold, branch redirect with squash, and HALT detection.
module etapa_if
    import proc_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [PC_W-1:0]    imem_addr,
    output logic               imem_rd,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] instruccion,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid,
    output logic               halted
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    addr_q;
    logic               inflight_q;
    logic [INSTR_W-1:0] instr_q;
    logic [PC_W-1:0]    pc_out_q;
    logic               valid_q;
    logic               halted_q;
    logic [PC_W-1:0]    pc_d;

    pc_next_mux u_pc_next_mux (
        .rst_n         (rst_n),
        .run           (state_q == RUN),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .pc_q          (pc_q),
        .addr_q        (addr_q),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd)
    );

    // Both the redirect and the normal advance continue from the issued address.
    assign pc_d = imem_addr + PC_W'(1);

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= RUN;
            pc_q       <= '0;
            addr_q     <= '0;
            inflight_q <= 1'b0;
            instr_q    <= NOP_WORD;
            pc_out_q   <= '0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    if (branch_taken) begin
                        pc_q       <= pc_d;
                        addr_q     <= imem_addr;
                        inflight_q <= 1'b1;
                        instr_q    <= NOP_WORD;
                        valid_q    <= 1'b0;
                    end else if (!stall) begin
                        pc_q       <= pc_d;
                        addr_q     <= imem_addr;
                        inflight_q <= 1'b1;
                        instr_q    <= imem_data;
                        pc_out_q   <= addr_q;
                        valid_q    <= inflight_q;
                        if (inflight_q && is_halt(imem_data)) begin
                            state_q  <= HALTED;
                            halted_q <= 1'b1;
                        end
                    end
                end
                HALTED: begin
                    instr_q <= NOP_WORD;
                    valid_q <= 1'b0;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign instruccion = instr_q;
    assign pc_out      = pc_out_q;
    assign valid       = valid_q;
    assign halted      = halted_q;

endmodule

// File: tb/tb_etapa_if.sv
// Scoreboard bench for etapa_if: the stimulus side predicts the in-order
// stream of delivered (pc, word) pairs; a negedge monitor checks the DUT.
module tb_etapa_if;
    import proc_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic               stall = 1'b0;
    logic               branch_taken = 1'b0;
    logic [PC_W-1:0]    branch_target = '0;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_rd;
    logic [INSTR_W-1:0] imem_data = '0;
    logic [INSTR_W-1:0] instruccion;
    logic [PC_W-1:0]    pc_out;
    logic               valid;
    logic               halted;

    always #5 clk = ~clk;

    etapa_if dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_rd       (imem_rd),
        .imem_data     (imem_data),
        .instruccion   (instruccion),
        .pc_out        (pc_out),
        .valid         (valid),
        .halted        (halted)
    );

    // Synchronous instruction ROM, one cycle of read latency.
    logic [INSTR_W-1:0] rom [256];
    always @(posedge clk) if (imem_rd) imem_data <= rom[imem_addr];

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] word;
        bit                 halt;
    } exp_t;

    exp_t            exp_q[$];
    int              n_checks = 0;
    int              n_errors = 0;
    bit              m_halted = 1'b0;
    bit              gen_halt = 1'b0;
    logic [PC_W-1:0] gen_pc = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Program order: sequential addresses (mod 256) from the last redirect, ending at a HALT word.
    function automatic void fill();
        exp_t e;
        while (!gen_halt && exp_q.size() < 4) begin
            e.pc   = gen_pc;
            e.word = rom[gen_pc];
            e.halt = (e.word[13:10] == 4'hF);
            exp_q.push_back(e);
            gen_halt = e.halt;
            gen_pc   = gen_pc + 8'd1;
        end
    endfunction

    // Monitor: compares whatever is presented, pops when decode consumes it.
    int since_br   = 3;
    bit br_stalled = 1'b0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst_n) begin
            since_br   = 3;
            br_stalled = 1'b0;
        end else begin
            if (since_br < 3) since_br++;
            if (valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_valid", 32'(pc_out), 32'hFFFF_FFFF);
                end else begin
                    e = exp_q[0];
                    check("pc_out", 32'(pc_out), 32'(e.pc));
                    check("instruccion", 32'(instruccion), 32'(e.word));
                    if (!stall || branch_taken || e.halt) begin
                        void'(exp_q.pop_front());
                        if (e.halt) m_halted = 1'b1;
                    end
                end
            end else if (m_halted || since_br == 1) begin
                check("bubble_word", 32'(instruccion), 32'(NOP_WORD));
            end
            if (since_br == 1 && !m_halted) begin
                check("branch_bubble", 32'(valid), 32'd0);
                if (stall && !branch_taken) br_stalled = 1'b1;
            end
            if (since_br == 2 && !br_stalled && !m_halted)
                check("branch_penalty", 32'(valid), 32'd1);
            check("halted", 32'(halted), 32'(m_halted));
            check("imem_rd", 32'(imem_rd), 32'(!m_halted));
            if (branch_taken && !m_halted) begin
                since_br   = 0;
                br_stalled = 1'b0;
            end
        end
    end

    // One cycle of stimulus starting at posedge+1; model update applied at the edge.
    task automatic cyc(input logic br, input logic [PC_W-1:0] tgt, input logic st);
        branch_taken  = br;
        branch_target = tgt;
        stall         = st;
        @(posedge clk);
        if (br && !m_halted) begin
            exp_q.delete();
            gen_pc   = tgt;
            gen_halt = 1'b0;
        end
        fill();
        #1;
    endtask

    task automatic do_reset(input int mode, input logic st, input logic br);
        logic [INSTR_W-1:0] w;
        rst_n         = 1'b0;
        stall         = st;
        branch_taken  = br;
        branch_target = 8'h55;
        for (int i = 0; i < 256; i++) begin
            if (mode == 2) begin
                w = 14'($urandom);
                w[13:10] = ($urandom_range(0, 99) == 0) ? HALT_OP : 4'($urandom_range(0, 14));
                rom[i] = w;
            end else begin
                rom[i] = 14'h0100 + 14'(i);
            end
        end
        if (mode == 1) rom[7] = {HALT_OP, 10'h007};
        @(posedge clk);
        exp_q.delete();
        #1;
        check("rst_instruccion", 32'(instruccion), 32'(NOP_WORD));
        check("rst_pc_out", 32'(pc_out), 32'd0);
        check("rst_valid", 32'(valid), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_imem_rd", 32'(imem_rd), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        rst_n        = 1'b1;
        stall        = 1'b0;
        branch_taken = 1'b0;
        m_halted     = 1'b0;
        gen_pc       = '0;
        gen_halt     = 1'b0;
        fill();
    endtask

    initial begin
        @(posedge clk);
        #1;
        // Sequential fetch, stall at pc_out=5, branches (incl. wrap and branch+stall), reset mid-stall.
        do_reset(0, 1'b0, 1'b0);
        for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h40, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'hFE, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h80, 1'b1);
        for (int i = 0; i < 4; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        do_reset(0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h10, 1'b0);
        do_reset(1, 1'b0, 1'b1);
        // HALT at address 7; later branch/stall pulses must be ignored.
        for (int i = 0; i < 14; i++) cyc(1'b0, 8'h00, 1'b0);
        cyc(1'b1, 8'h20, 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
        cyc(1'b1, 8'h30, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, 8'h00, 1'b0);
        do_reset(0, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) cyc(1'b0, 8'h00, 1'b0);
        // Randomized ROM contents and control traffic.
        for (int r = 0; r < 8; r++) begin
            do_reset(2, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int i = 0; i < 300; i++)
                cyc(1'($urandom_range(0, 9) == 0), 8'($urandom), 1'($urandom_range(0, 4) == 0));
        end
        @(posedge clk);
        #1;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/etapa_if.md
Name: etapa_if

Overview:
- Instruction-fetch stage plus IF/ID pipeline register.
- Sits directly upstream of the decode stage and drives its 14-bit `instruccion` input.
- Generates the PC and reads a synchronous instruction ROM with 1-cycle read latency.
- Handles stall from the hazard logic, taken-branch redirect with squash, and HALT detection.

Parameters:
- PC_W, 8, width of PC and instruction-memory address.
- INSTR_W, 14, instruction width; opcode is bits [13:10].
- HALT_OP, 4'hF, opcode that stops fetching.
- NOP_WORD, 14'h0000, word driven on `instruccion` for bubbles.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- stall  in  1  hazard unit: hold PC and IF/ID.
- branch_taken  in  1  redirect fetch this cycle.
- branch_target  in  PC_W  redirect address.
- imem_addr  out  PC_W  ROM address (combinational).
- imem_rd  out  1  ROM read enable (combinational).
- imem_data  in  INSTR_W  ROM word for the address presented the previous cycle.
- instruccion  out  INSTR_W  IF/ID instruction to decode.
- pc_out  out  PC_W  address of `instruccion`.
- valid  out  1  `instruccion` is a real instruction; 0 means bubble.
- halted  out  1  fetch stopped by HALT.

Behaviour:

Internal state:
- `pc_q`: next address to issue.
- `addr_q`: address in flight.
- `inflight_v`: in-flight word is live.
- FSM {RUN, HALTED}.

Reset (rst_n=0 at an edge):
- pc_q=0, addr_q=0, inflight_v=0, state=RUN.
- instruccion=NOP_WORD, pc_out=0, valid=0, halted=0.
- While rst_n=0: imem_rd=0, imem_addr=0.

RUN, cases in priority order:
1. branch_taken=1 (overrides stall):
   - imem_addr=branch_target, imem_rd=1.
   - pc_q<=branch_target+1, addr_q<=branch_target, inflight_v<=1.
   - IF/ID <= {NOP_WORD, pc_out unchanged, valid=0}; the in-flight word is squashed.
   - Penalty: exactly 1 bubble.
2. stall=1:
   - imem_addr=addr_q, imem_rd=1, so the re-read keeps imem_data stable for the next cycle.
   - pc_q, addr_q, inflight_v and IF/ID all hold.
3. Otherwise:
   - imem_addr=pc_q, imem_rd=1.
   - pc_q<=pc_q+1, addr_q<=pc_q, inflight_v<=1.
   - IF/ID <= {imem_data, addr_q, inflight_v}.

HALT detection:
- Applies only in case 3, when inflight_v=1 and imem_data[13:10]==HALT_OP.
- The HALT word loads normally with valid=1; state<=HALTED and halted<=1 at the same edge.
- A HALT word squashed by a branch, or held by stall, does not halt.

HALTED:
- imem_rd=0, imem_addr=pc_q.
- Next edge: IF/ID <= {NOP_WORD, pc_out hold, valid=0}; thereafter held.
- stall and branch_taken are ignored.
- Exit only via reset.

Latency:
- Address issued in cycle t appears on `instruccion` in cycle t+2, with no stall or branch in t and t+1.
- After reset deasserts at the edge ending cycle 0, the first valid=1 is in cycle 2 with pc_out=0.

Arithmetic:
- PC increment is modulo 2^PC_W: 8'hFF+1 -> 8'h00, no flag.

Simultaneous events:
- Branch and stall together: branch wins.
- Reset mid-stall or mid-branch: reset wins and all state clears at that edge.
- Stall held for N cycles: outputs identical for N cycles, then resume with no lost or duplicated instruction.

Decomposition:
- Shared package `proc_pkg`:
  - constants INSTR_W, PC_W, HALT_OP, NOP_WORD;
  - opcode field bounds OPC_HI=13, OPC_LO=10;
  - FSM state encoding.
- No sub-module required.
- The PC/next-address mux may be a small `pc_next_mux` combinational sub-module.

Test Plan:
1. Reset, then run with ROM[i]=14'h0100+i -> cycles 2,3,4 show instruccion 0x0100,0x0101,0x0102 with pc_out 0,1,2 and valid=1.
2. Stall high for 3 cycles while pc_out=5 -> instruccion/pc_out stay at ROM[5]/5 for 3 cycles, then 6,7 follow with no skip or repeat.
3. branch_taken with target 0x40 while pc_out=3 -> one valid=0 NOP cycle, then pc_out=0x40, 0x41 with correct ROM words; squashed address 4 never appears with valid=1.
4. ROM[7] opcode 4'hF -> pc_out=7 valid=1 once, halted=1 from that cycle, then valid=0 and imem_rd=0; branch/stall pulses have no effect; reset restarts at 0.
5. Start near the top via branch to 0xFE -> pc_out sequence 0xFE,0xFF,0x00.
6. Branch and stall asserted together, and reset asserted during a stall -> branch taken; reset clears all outputs to NOP_WORD/0/valid=0 at that edge.
